// File: rtl/shift_pkg.sv
// Shared types for the shifter result stage: default widths, buffered entry layout, sticky mask.
// The sticky bit exists only when SHIFT_STICKY_EN is defined.
package shift_pkg;

   localparam int unsigned DATA_W  = 5;
   localparam int unsigned SHIFT_W = 2;

   typedef struct packed {
      logic [DATA_W-1:0] y;
      logic              zero;
`ifdef SHIFT_STICKY_EN
      logic              sticky;
`endif
   } entry_t;

   // Bits of A that a right shift by b discards.
   function automatic logic [DATA_W-1:0] sticky_mask(input logic [SHIFT_W-1:0] b);
      return (DATA_W'(1) << b) - DATA_W'(1);
   endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// Generic 2-entry valid/ready skid buffer on a packed entry.
// in_ready depends only on registered state, so out_ready never reaches the upstream combinationally.
module shift_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid;
   logic [W-1:0] main_data;
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         in_xfer;

   assign in_ready  = !skid_valid;
   assign in_xfer   = in_valid && !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!main_valid || out_ready) begin
         // Main slot frees up: the skid entry is older than any new input, so it goes first.
         if (skid_valid) begin
            main_data  <= skid_data;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/shift_result_stage.sv
// Registered output stage behind the right shifter: captures y, derives zero/sticky flags,
// presents them through a 2-entry skid buffer and counts delivered results. Option: SHIFT_STICKY_EN.
module shift_result_stage
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned SHW   = SHIFT_W,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [SHW-1:0]   in_bshift,
   input  logic [WIDTH-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_sticky,
   output logic [CNT_W-1:0] result_cnt
);

   entry_t in_entry;
   entry_t out_entry;

   // Flags are taken from the shifter result at capture time, not re-derived downstream.
   always_comb begin
      in_entry      = '0;
      in_entry.y    = in_y;
      in_entry.zero = (in_y == '0);
`ifdef SHIFT_STICKY_EN
      in_entry.sticky = |(in_a & sticky_mask(in_bshift));
`endif
   end

`ifndef SHIFT_STICKY_EN
   logic unused_operands;
   assign unused_operands = ^{in_a, in_bshift};
`endif

   shift_skid_buf #(
      .W($bits(entry_t))
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_entry),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_entry)
   );

   assign out_y    = out_entry.y;
   assign out_zero = out_entry.zero;
`ifdef SHIFT_STICKY_EN
   assign out_sticky = out_entry.sticky;
`else
   assign out_sticky = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_cnt <= '0;
      end else if (out_valid && out_ready) begin
         result_cnt <= result_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_result_stage.sv
// Self-checking bench for shift_result_stage: directed scenarios plus random traffic
// checked against a queue-based FIFO reference model.
module tb_shift_result_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_a;
   logic [1:0] in_bshift;
   logic [4:0] in_y;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_y;
   logic       out_zero;
   logic       out_sticky;
   logic [7:0] result_cnt;

   typedef struct {
      int unsigned y;
      bit          zero;
      bit          sticky;
   } exp_t;

   exp_t        q[$];
   int unsigned cnt_model;
   int          n_checks = 0;
   int          n_errors = 0;

`ifdef SHIFT_STICKY_EN
   localparam bit STICKY_ON = 1'b1;
`else
   localparam bit STICKY_ON = 1'b0;
`endif

   shift_result_stage #(
      .WIDTH(5),
      .SHW  (2),
      .CNT_W(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_bshift (in_bshift),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .out_sticky(out_sticky),
      .result_cnt(result_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int unsigned a, input int unsigned b);
      exp_t e;
      e.y      = (a >> b) % 32;
      e.zero   = (e.y == 0);
      e.sticky = STICKY_ON && ((a % (1 << b)) != 0);
      return e;
   endfunction

   // One clock: check the state settled after the last edge, then drive the next inputs
   // and predict what the coming edge moves in and out.
   task automatic cycle(input bit v, input int unsigned a, input int unsigned b,
                        input bit ordy, output bit acc);
      int unsigned occ;
      @(negedge clk);
      occ = q.size();
      chk("out_valid", out_valid, occ > 0);
      chk("in_ready", in_ready, occ < 2);
      chk("result_cnt", result_cnt, cnt_model % 256);
      if (occ > 0) begin
         chk("out_y", out_y, q[0].y);
         chk("out_zero", out_zero, q[0].zero);
         chk("out_sticky", out_sticky, q[0].sticky);
      end
      in_valid  = v;
      in_a      = 5'(a);
      in_bshift = 2'(b);
      in_y      = 5'(a) >> b;
      out_ready = ordy;
      acc = v && (occ < 2);
      if (occ > 0 && ordy) begin
         void'(q.pop_front());
         cnt_model++;
      end
      if (acc) q.push_back(model(a % 32, b % 4));
   endtask

   task automatic idle(input int n, input bit ordy);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, ordy, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_bshift = '0;
      in_y      = '0;
      out_ready = 1'b0;
      q.delete();
      cnt_model = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit          acc;
      bit          pv;
      int unsigned pa, pb;
      int unsigned cnt0;
      int          guard;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_bshift = '0;
      in_y      = '0;
      out_ready = 1'b0;
      cnt_model = 0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_result_cnt", result_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_out_sticky", out_sticky, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single transfer.
      cycle(1'b1, 5'b10110, 2, 1'b1, acc);
      cycle(1'b0, 0, 0, 1'b1, acc);
      chk("single_y", out_y, 5'b00101);
      chk("single_zero", out_zero, 0);
      chk("single_sticky", out_sticky, STICKY_ON);
      cycle(1'b0, 0, 0, 1'b1, acc);
      chk("single_cnt", result_cnt, 1);

      // Backpressure: two entries held, third stays upstream.
      cycle(1'b1, 5'b11111, 1, 1'b0, acc);
      cycle(1'b1, 5'b10000, 3, 1'b0, acc);
      cycle(1'b1, 5'b01101, 2, 1'b0, acc);
      chk("bp_third_refused", acc, 0);
      chk("bp_in_ready", in_ready, 0);
      guard = 0;
      do begin
         cycle(1'b1, 5'b01101, 2, 1'b1, acc);
         guard++;
      end while (!acc && guard < 8);
      chk("bp_third_accepted", acc, 1);
      idle(4, 1'b1);

      // Streaming: ten back-to-back results.
      cnt0 = cnt_model;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, $urandom_range(0, 31), $urandom_range(0, 3), 1'b1, acc);
         chk("stream_acc", acc, 1);
      end
      idle(3, 1'b1);
      chk("stream_cnt", result_cnt, (cnt0 + 10) % 256);

      // Zero result and zero shift.
      cycle(1'b1, 5'b00011, 3, 1'b1, acc);
      cycle(1'b1, 5'b00011, 0, 1'b1, acc);
      chk("bnd_zero", out_zero, 1);
      chk("bnd_sticky", out_sticky, STICKY_ON);
      cycle(1'b0, 0, 0, 1'b1, acc);
      chk("bnd_y_b0", out_y, 5'b00011);
      chk("bnd_sticky_b0", out_sticky, 0);
      chk("bnd_zero_b0", out_zero, 0);
      idle(2, 1'b1);

      // Random traffic; upstream holds an offer until it is accepted.
      pv = 1'b0;
      pa = 0;
      pb = 0;
      for (int i = 0; i < 400; i++) begin
         if (!pv) begin
            pv = ($urandom_range(0, 3) != 0);
            pa = $urandom_range(0, 31);
            pb = $urandom_range(0, 3);
         end
         cycle(pv, pa, pb, ($urandom_range(0, 3) != 0), acc);
         if (acc) pv = 1'b0;
      end
      idle(4, 1'b1);

      // Counter wrap after exactly 256 deliveries.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         cycle(1'b1, $urandom_range(0, 31), $urandom_range(0, 3), 1'b1, acc);
      end
      idle(3, 1'b1);
      chk("wrap_cnt", result_cnt, 0);

      // Reset with two entries buffered.
      cycle(1'b1, 5'b11001, 1, 1'b0, acc);
      cycle(1'b1, 5'b00111, 2, 1'b0, acc);
      cycle(1'b0, 0, 0, 1'b0, acc);
      chk("mid_full", in_ready, 0);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_out_valid", out_valid, 0);
      chk("mid_in_ready", in_ready, 1);
      chk("mid_out_y", out_y, 0);
      chk("mid_cnt", result_cnt, 0);
      q.delete();
      cnt_model = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(6, 1'b1);
      chk("mid_after_cnt", result_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
